pe_op_sequencer: RTL

- Sits between the vector decode stage and the PE array.
- Accepts one decoded arithmetic vector instruction (PE op, output mode, saturation mode, register indices, vl, SEW) through a valid/ready handshake.
- Breaks the instruction into beats. Each beat is NUM_PE 32-bit words and carries a byte-enable mask.
- Throttles issue against a bound on in-flight beats, then waits for PE writebacks to drain before it signals completion.

---
 rtl/pe_op_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pe_op_sequencer.sv
// rtl/pe_op_sequencer.sv - splits one decoded vector instruction into PE-array beats
// and throttles them against the number of beats still awaiting writeback.
module pe_op_sequencer #(
    parameter int NUM_PE  = 4,
    parameter int VLEN    = 512,
    parameter int MAX_OUT = 4,
    localparam int VL_W      = $clog2(VLEN / 8) + 1,
    localparam int MAX_BEATS = VLEN / (32 * NUM_PE),
    localparam int IDX_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
    localparam int BE_W      = NUM_PE * 4
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [3:0]       arith_op_i,
    input  logic [1:0]       out_mode_i,
    input  logic [1:0]       sat_mode_i,
    input  logic [4:0]       vs1_i,
    input  logic [4:0]       vs2_i,
    input  logic [4:0]       vd_i,
    input  logic [VL_W-1:0]  vl_i,
    input  logic [1:0]       sew_i,
    output logic             beat_valid_o,
    input  logic             beat_ready_i,
    output logic [3:0]       beat_op_o,
    output logic [1:0]       beat_mode_o,
    output logic [1:0]       beat_sat_o,
    output logic [4:0]       beat_vs1_o,
    output logic [4:0]       beat_vs2_o,
    output logic [4:0]       beat_vd_o,
    output logic [IDX_W-1:0] beat_idx_o,
    output logic [BE_W-1:0]  beat_be_o,
    output logic             beat_last_o,
    input  logic             wb_done_i,
    output logic             busy_o,
    output logic             done_o
);
    localparam int BEATS_W   = IDX_W + 1;
    localparam int TAIL_W    = $clog2(BE_W);
    localparam int OUT_W     = $clog2(MAX_OUT + 1);
    localparam int CAP_BYTES = VLEN / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [OUT_W-1:0]   outstanding;
    logic [OUT_W-1:0]   outstanding_next;
    logic [BEATS_W-1:0] beats_r;
    logic [TAIL_W-1:0]  tail_r;

    logic [1:0]         sew_eff;
    logic [VL_W-1:0]    cap_elems;
    logic [VL_W-1:0]    elems;
    logic [VL_W-1:0]    bytes;
    logic [BEATS_W-1:0] beats_calc;
    logic [TAIL_W-1:0]  tail_calc;

    logic accept;
    logic issue_ok;
    logic last_hit;
    logic xfer;
    logic wb_ok;

    // Byte count is clamped to the register capacity before being split into beats.
    assign sew_eff    = (sew_i == 2'd3) ? 2'd2 : sew_i;
    assign cap_elems  = VL_W'(CAP_BYTES) >> sew_eff;
    assign elems      = (vl_i > cap_elems) ? cap_elems : vl_i;
    assign bytes      = elems << sew_eff;
    assign beats_calc = BEATS_W'((bytes + VL_W'(BE_W - 1)) >> TAIL_W);
    assign tail_calc  = bytes[TAIL_W-1:0];

    assign accept        = (state == S_IDLE) && instr_valid_i;
    assign issue_ok      = (state == S_ISSUE) && (outstanding < OUT_W'(MAX_OUT));
    assign last_hit      = ({1'b0, beat_idx_o} == (beats_r - 1'b1));
    assign xfer          = issue_ok && beat_ready_i;
    assign wb_ok         = wb_done_i && (outstanding != '0);

    assign instr_ready_o = (state == S_IDLE);
    assign beat_valid_o  = issue_ok;
    assign beat_last_o   = issue_ok && last_hit;
    assign busy_o        = (state != S_IDLE);
    assign done_o        = (state == S_DONE);

    always_comb begin
        beat_be_o = '0;
        if (issue_ok) begin
            if (last_hit && (tail_r != '0)) begin
                beat_be_o = ~({BE_W{1'b1}} << tail_r);
            end else begin
                beat_be_o = '1;
            end
        end
    end

    // A writeback with nothing in flight is dropped so the counter never wraps.
    always_comb begin
        outstanding_next = outstanding;
        if (xfer && !wb_ok) begin
            outstanding_next = outstanding + 1'b1;
        end else if (!xfer && wb_ok) begin
            outstanding_next = outstanding - 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (instr_valid_i) begin
                    state_next = (beats_calc == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (xfer && last_hit) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outstanding_next == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            outstanding <= '0;
            beats_r     <= '0;
            tail_r      <= '0;
            beat_idx_o  <= '0;
            beat_op_o   <= '0;
            beat_mode_o <= '0;
            beat_sat_o  <= '0;
            beat_vs1_o  <= '0;
            beat_vs2_o  <= '0;
            beat_vd_o   <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (accept) begin
                beats_r     <= beats_calc;
                tail_r      <= tail_calc;
                beat_idx_o  <= '0;
                beat_op_o   <= arith_op_i;
                beat_mode_o <= out_mode_i;
                beat_sat_o  <= sat_mode_i;
                beat_vs1_o  <= vs1_i;
                beat_vs2_o  <= vs2_i;
                beat_vd_o   <= vd_i;
            end else if (xfer) begin
                beat_idx_o <= beat_idx_o + 1'b1;
            end
        end
    end
endmodule
